// File: rtl/vdp_vram_slot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vdp_vram_pkg
// Purpose : Shared types and constants for the VRAM slot arbiter.
//           - slot_owner_t : which requester owns the current 4-clock slot.
//           - PH_*         : slot phase encodings carried in cx[1:0].
//           - Default refresh constants and bus widths.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package vdp_vram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    CPU  = 2'd2,
    CMD  = 2'd3
  } slot_owner_t;

  localparam logic [1:0] PH_DL = 2'd0;
  localparam logic [1:0] PH_DA = 2'd1;
  localparam logic [1:0] PH_AP = 2'd2;
  localparam logic [1:0] PH_FS = 2'd3;

  localparam int REFRESH_SLOTS_DEF     = 16;
  localparam int FORCED_REFRESH_CX_DEF = 723;

  localparam int CX_W    = 11;
  localparam int ADDR_W  = 17;
  localparam int WDATA_W = 8;
  localparam int RDATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/vdp_vram_slot_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : vdp_vram_slot_arbiter_if
// Purpose : Bundles the slot timing input, the three requester ports and the
//           VRAM-side port of the slot arbiter.
// Modports: master - environment side (drives cx, requests, vram_rdata)
//           slave  - arbiter side (drives acks, rdata, vram_* outputs)
// Rev     : 1.0  initial release
// ============================================================================
interface vdp_vram_slot_arbiter_if;
  import vdp_vram_pkg::*;

  logic [CX_W-1:0]    cx;
  logic               super_res_drawing;
  logic [ADDR_W-1:0]  super_res_vram_addr;

  logic               cpu_req;
  logic               cpu_wr;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [WDATA_W-1:0] cpu_wdata;
  logic               cpu_ack;
  logic [RDATA_W-1:0] cpu_rdata;

  logic               cmd_req;
  logic               cmd_wr;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [WDATA_W-1:0] cmd_wdata;
  logic               cmd_ack;
  logic [RDATA_W-1:0] cmd_rdata;

  logic [RDATA_W-1:0] vram_rdata;
  logic [ADDR_W-1:0]  vram_addr;
  logic [WDATA_W-1:0] vram_wdata;
  logic               vram_we;
  logic               vram_refresh;

  modport master (
    output cx, super_res_drawing, super_res_vram_addr,
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output cmd_req, cmd_wr, cmd_addr, cmd_wdata,
    input  cmd_ack, cmd_rdata,
    output vram_rdata,
    input  vram_addr, vram_wdata, vram_we, vram_refresh
  );

  modport slave (
    input  cx, super_res_drawing, super_res_vram_addr,
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  cmd_req, cmd_wr, cmd_addr, cmd_wdata,
    output cmd_ack, cmd_rdata,
    input  vram_rdata,
    output vram_addr, vram_wdata, vram_we, vram_refresh
  );

endinterface
`default_nettype wire

// File: rtl/vdp_vram_slot_arbiter_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module  : vdp_refresh_timer
// Purpose : Counts slots and issues a one-clock refresh strobe during FS,
//           either every REFRESH_SLOTS slots or in the slot containing
//           FORCED_REFRESH_CX. A coincident forced/periodic refresh gives a
//           single strobe and the counter restarts.
// Ports   : clk      - pixel clock
//           reset_n  - asynchronous active-low reset
//           cx       - horizontal counter (cx[1:0] = slot phase)
//           refresh  - registered strobe, high for the FS clock only
// Rev     : 1.0  initial release
// ============================================================================
module vdp_refresh_timer
  import vdp_vram_pkg::*;
#(
  parameter int REFRESH_SLOTS     = REFRESH_SLOTS_DEF,
  parameter int FORCED_REFRESH_CX = FORCED_REFRESH_CX_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [CX_W-1:0] cx,
  output logic            refresh
);

  localparam int              CNT_W     = (REFRESH_SLOTS > 1) ? $clog2(REFRESH_SLOTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_SLOTS - 1);
  localparam logic [CX_W-1:0]  FORCED_CX = CX_W'(FORCED_REFRESH_CX);

  logic [CNT_W-1:0] slot_cnt;
  logic             wrap;
  logic             forced;

  assign wrap   = (slot_cnt == CNT_LAST);
  // Strobe is registered on the AP->FS edge, so the forced compare is done
  // per slot (upper cx bits) to land the pulse on the FS clock of that slot.
  assign forced = (cx[CX_W-1:2] == FORCED_CX[CX_W-1:2]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= '0;
      refresh  <= 1'b0;
    end else begin
      refresh <= 1'b0;
      if (cx[1:0] == PH_AP) begin
        refresh  <= wrap | forced;
        slot_cnt <= wrap ? '0 : slot_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vdp_vram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vdp_vram_slot_arbiter
// Purpose : Divides the shared VRAM port into 4-clock slots (DL, DA, AP, FS)
//           and grants each slot to the display fetch, the CPU or the
//           command engine. Display has absolute priority; CPU and CMD
//           alternate when both request. Also schedules refresh strobes.
// Ports   : clk      - pixel clock, rising edge
//           reset_n  - asynchronous active-low reset
//           bus      - vdp_vram_slot_arbiter_if.slave: cx, requester ports,
//                      VRAM address/data/strobe outputs
// Rev     : 1.0  initial release
// ============================================================================
module vdp_vram_slot_arbiter
  import vdp_vram_pkg::*;
#(
  parameter int REFRESH_SLOTS     = REFRESH_SLOTS_DEF,
  parameter int FORCED_REFRESH_CX = FORCED_REFRESH_CX_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  vdp_vram_slot_arbiter_if.slave   bus
);

  logic [1:0]         phase;
  slot_owner_t        owner;
  slot_owner_t        rr_last;
  slot_owner_t        next_owner;
  logic               wr_pend;
  logic [ADDR_W-1:0]  addr_q;
  logic [WDATA_W-1:0] wdata_q;
  logic               we_q;
  logic               cpu_ack_q;
  logic               cmd_ack_q;
  logic [RDATA_W-1:0] cpu_rdata_q;
  logic [RDATA_W-1:0] cmd_rdata_q;
  logic               refresh;

  assign phase = bus.cx[1:0];

  // Owner for the next slot. rr_last only ever holds CPU or CMD, so on a
  // tie exactly one of the two requesters wins.
  always_comb begin
    next_owner = IDLE;
    if (bus.super_res_drawing) begin
      next_owner = DISP;
    end else if (bus.cpu_req && (!bus.cmd_req || rr_last == CMD)) begin
      next_owner = CPU;
    end else if (bus.cmd_req) begin
      next_owner = CMD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner       <= IDLE;
      rr_last     <= CMD;
      wr_pend     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cmd_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      cmd_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      cmd_ack_q <= 1'b0;
      case (phase)
        // FS -> DL edge: decide the owner and latch its request.
        PH_FS: begin
          owner <= next_owner;
          case (next_owner)
            CPU: begin
              addr_q  <= bus.cpu_addr;
              wdata_q <= bus.cpu_wdata;
              wr_pend <= bus.cpu_wr;
            end
            CMD: begin
              addr_q  <= bus.cmd_addr;
              wdata_q <= bus.cmd_wdata;
              wr_pend <= bus.cmd_wr;
            end
            DISP: begin
              addr_q  <= bus.super_res_vram_addr;
              wdata_q <= '0;
              wr_pend <= 1'b0;
            end
            default: begin
              addr_q  <= '0;
              wdata_q <= '0;
              wr_pend <= 1'b0;
            end
          endcase
        end
        // DL -> DA edge: the write strobe covers exactly the DA clock.
        PH_DL: begin
          we_q <= wr_pend;
        end
        // DA -> AP edge: end the strobe, capture read data, acknowledge.
        PH_DA: begin
          we_q <= 1'b0;
          if (owner == CPU) begin
            cpu_ack_q <= 1'b1;
            rr_last   <= CPU;
            if (!wr_pend) cpu_rdata_q <= bus.vram_rdata;
          end
          if (owner == CMD) begin
            cmd_ack_q <= 1'b1;
            rr_last   <= CMD;
            if (!wr_pend) cmd_rdata_q <= bus.vram_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  vdp_refresh_timer #(
    .REFRESH_SLOTS     (REFRESH_SLOTS),
    .FORCED_REFRESH_CX (FORCED_REFRESH_CX)
  ) u_refresh_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .cx      (bus.cx),
    .refresh (refresh)
  );

  assign bus.vram_addr    = addr_q;
  assign bus.vram_wdata   = wdata_q;
  assign bus.vram_we      = we_q;
  assign bus.vram_refresh = refresh;
  assign bus.cpu_ack      = cpu_ack_q;
  assign bus.cmd_ack      = cmd_ack_q;
  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.cmd_rdata    = cmd_rdata_q;

endmodule
`default_nettype wire
